// File: rtl/chip8_pkg.sv
// Shared framebuffer geometry, draw-engine state encoding and the row-clip helper.
package chip8_pkg;

   localparam int FB_ROWS  = 32;
   localparam int FB_COLS  = 64;
   localparam int FB_ROW_W = 5;
   localparam logic [11:0] FONT_BASE = 12'h050;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_RD,
      ST_WR,
      ST_DONE
   } draw_state_e;

   // Rows actually drawn: sprite height clipped at the bottom edge (room = rows below y0).
   function automatic logic [5:0] clip_rows(input logic [3:0] n, input logic [5:0] room);
      return ({2'b00, n} < room) ? {2'b00, n} : room;
   endfunction

endpackage

// File: rtl/sprite_draw_engine_if.sv
// CPU request/status, sprite RAM read port and framebuffer row port of the draw engine.
interface sprite_draw_engine_if
   import chip8_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int FB_COLS = 64
);

   logic                draw_start;
   logic                clear_start;
   logic [7:0]          sprite_x;
   logic [7:0]          sprite_y;
   logic [3:0]          sprite_n;
   logic [ADDR_W-1:0]   sprite_addr;
   logic                busy;
   logic                done;
   logic                collision;

   logic                ram_rd_en;
   logic [ADDR_W-1:0]   ram_rd_addr;
   logic [7:0]          ram_rd_data;

   logic [FB_ROW_W-1:0] fb_addr;
   logic                fb_rd_en;
   logic [FB_COLS-1:0]  fb_rd_data;
   logic                fb_we;
   logic [FB_COLS-1:0]  fb_wr_data;

   modport master (
      input  draw_start, clear_start, sprite_x, sprite_y, sprite_n, sprite_addr,
      output busy, done, collision,
      output ram_rd_en, ram_rd_addr,
      input  ram_rd_data,
      output fb_addr, fb_rd_en, fb_we, fb_wr_data,
      input  fb_rd_data
   );

   modport slave (
      output draw_start, clear_start, sprite_x, sprite_y, sprite_n, sprite_addr,
      input  busy, done, collision,
      input  ram_rd_en, ram_rd_addr,
      output ram_rd_data,
      input  fb_addr, fb_rd_en, fb_we, fb_wr_data,
      output fb_rd_data
   );

endinterface

// File: rtl/sprite_row_xor.sv
// Places one sprite byte at column x0 in a framebuffer row (right edge clipped, no wrap),
// XORs it in and flags any lit pixel that the sprite turns off.
module sprite_row_xor
   import chip8_pkg::*;
#(
   parameter int FB_COLS = 64,
   parameter int X_W     = 6
) (
   input  logic [FB_COLS-1:0] old_row,
   input  logic [7:0]         sprite_byte,
   input  logic [X_W-1:0]     x0,
   output logic [FB_COLS-1:0] new_row,
   output logic               hit
);

   logic [FB_COLS-1:0] mask;

   // Column 0 is the row MSB, so a right shift moves pixels rightwards and drops overflow.
   always_comb begin
      mask    = {sprite_byte, {(FB_COLS-8){1'b0}}} >> x0;
      new_row = old_row ^ mask;
      hit     = |(old_row & mask);
   end

endmodule

// File: rtl/sprite_draw_engine.sv
// Draw (Dxyn) and clear sequencer for the 64x32 framebuffer: one read/write pair per sprite row,
// draw done at accept+2m+1, clear done at accept+33; requests outside IDLE are dropped.
module sprite_draw_engine
   import chip8_pkg::*;
#(
   parameter int FB_ROWS = 32,
   parameter int FB_COLS = 64,
   parameter int ADDR_W  = 12
) (
   input logic           clock,
   input logic           resetN,
   sprite_draw_engine_if.master bus
);

   localparam int ROW_W = $clog2(FB_ROWS);
   localparam int X_W   = $clog2(FB_COLS);

   draw_state_e         state_q, state_d;
   logic [X_W-1:0]      x0_q, x0_d;
   logic [ROW_W-1:0]    y0_q, y0_d;
   logic [5:0]          m_q, m_d;
   logic [5:0]          r_q, r_d;
   logic [ADDR_W-1:0]   i_q, i_d;
   logic                collision_q, collision_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ram_rd_en_q, ram_rd_en_d;
   logic [ADDR_W-1:0]   ram_rd_addr_q, ram_rd_addr_d;
   logic                fb_rd_en_q, fb_rd_en_d;
   logic                fb_we_q, fb_we_d;
   logic [ROW_W-1:0]    fb_addr_q, fb_addr_d;

   logic [5:0]          r_nxt;
   logic [5:0]          room;
   logic [5:0]          m_new;
   logic [FB_COLS-1:0]  new_row;
   logic                hit;

   sprite_row_xor #(
      .FB_COLS (FB_COLS),
      .X_W     (X_W)
   ) u_row_xor (
      .old_row     (bus.fb_rd_data),
      .sprite_byte (bus.ram_rd_data),
      .x0          (x0_q),
      .new_row     (new_row),
      .hit         (hit)
   );

   // Strobes and addresses are computed for the state being entered so they leave a flop.
   always_comb begin
      state_d       = state_q;
      x0_d          = x0_q;
      y0_d          = y0_q;
      m_d           = m_q;
      r_d           = r_q;
      i_d           = i_q;
      collision_d   = collision_q;
      done_d        = 1'b0;
      ram_rd_en_d   = 1'b0;
      ram_rd_addr_d = '0;
      fb_rd_en_d    = 1'b0;
      fb_we_d       = 1'b0;
      fb_addr_d     = '0;
      r_nxt         = r_q + 6'd1;
      room          = 6'(FB_ROWS) - {1'b0, bus.sprite_y[ROW_W-1:0]};
      m_new         = clip_rows(bus.sprite_n, room);

      case (state_q)
         ST_IDLE: begin
            if (bus.clear_start) begin
               state_d     = ST_CLR;
               r_d         = '0;
               collision_d = 1'b0;
               fb_we_d     = 1'b1;
            end else if (bus.draw_start) begin
               x0_d        = bus.sprite_x[X_W-1:0];
               y0_d        = bus.sprite_y[ROW_W-1:0];
               m_d         = m_new;
               r_d         = '0;
               i_d         = bus.sprite_addr;
               collision_d = 1'b0;
               if (m_new == 6'd0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d       = ST_RD;
                  ram_rd_en_d   = 1'b1;
                  ram_rd_addr_d = bus.sprite_addr;
                  fb_rd_en_d    = 1'b1;
                  fb_addr_d     = bus.sprite_y[ROW_W-1:0];
               end
            end
         end
         ST_CLR: begin
            if (r_q == 6'(FB_ROWS-1)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               r_d       = r_nxt;
               fb_we_d   = 1'b1;
               fb_addr_d = r_nxt[ROW_W-1:0];
            end
         end
         ST_RD: begin
            state_d   = ST_WR;
            fb_we_d   = 1'b1;
            fb_addr_d = fb_addr_q;
         end
         ST_WR: begin
            collision_d = collision_q | hit;
            r_d         = r_nxt;
            if (r_nxt == m_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d       = ST_RD;
               ram_rd_en_d   = 1'b1;
               ram_rd_addr_d = i_q + ADDR_W'(r_nxt);
               fb_rd_en_d    = 1'b1;
               fb_addr_d     = y0_q + r_nxt[ROW_W-1:0];
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q       <= ST_IDLE;
         x0_q          <= '0;
         y0_q          <= '0;
         m_q           <= '0;
         r_q           <= '0;
         i_q           <= '0;
         collision_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         ram_rd_en_q   <= 1'b0;
         ram_rd_addr_q <= '0;
         fb_rd_en_q    <= 1'b0;
         fb_we_q       <= 1'b0;
         fb_addr_q     <= '0;
      end else begin
         state_q       <= state_d;
         x0_q          <= x0_d;
         y0_q          <= y0_d;
         m_q           <= m_d;
         r_q           <= r_d;
         i_q           <= i_d;
         collision_q   <= collision_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         ram_rd_en_q   <= ram_rd_en_d;
         ram_rd_addr_q <= ram_rd_addr_d;
         fb_rd_en_q    <= fb_rd_en_d;
         fb_we_q       <= fb_we_d;
         fb_addr_q     <= fb_addr_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.collision   = collision_q;
   assign bus.ram_rd_en   = ram_rd_en_q;
   assign bus.ram_rd_addr = ram_rd_addr_q;
   assign bus.fb_rd_en    = fb_rd_en_q;
   assign bus.fb_we       = fb_we_q;
   assign bus.fb_addr     = fb_addr_q;
   // Row data arrives one cycle after the read, so the write word is formed combinationally in WR.
   assign bus.fb_wr_data  = (state_q == ST_WR) ? new_row : '0;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine with behavioural sprite RAM and framebuffer.
module tb_sprite_draw_engine;
   import chip8_pkg::*;

   logic clock = 1'b0;
   logic resetN;
   int   cyc = 0;

   sprite_draw_engine_if #(.ADDR_W(12), .FB_COLS(64)) bus ();

   sprite_draw_engine #(.FB_ROWS(32), .FB_COLS(64), .ADDR_W(12)) dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   logic [7:0]  ram [4096];
   logic [63:0] fb  [32];

   always @(posedge clock) begin
      if (bus.ram_rd_en) bus.ram_rd_data <= ram[bus.ram_rd_addr];
      if (bus.fb_rd_en)  bus.fb_rd_data  <= fb[bus.fb_addr];
      if (bus.fb_we)     fb[bus.fb_addr] <= bus.fb_wr_data;
   end

   int          checks = 0;
   int          errors = 0;
   int          t0 = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          viol = 0;
   int          wr_off [64];
   logic [4:0]  wr_row [64];
   logic [11:0] rd_log [64];

   always @(negedge clock) begin
      if (bus.fb_we && bus.fb_rd_en) viol++;
      if ((!bus.busy || bus.done) && (bus.fb_we || bus.fb_rd_en || bus.ram_rd_en)) viol++;
      if (bus.fb_we) begin
         if (wr_cnt < 64) begin
            wr_off[wr_cnt] = cyc - t0;
            wr_row[wr_cnt] = bus.fb_addr;
         end
         wr_cnt++;
      end
      if (bus.ram_rd_en) begin
         if (rd_cnt < 64) rd_log[rd_cnt] = bus.ram_rd_addr;
         rd_cnt++;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Issues one request and waits (bounded) for done; inj_k>0 pulses a stray draw mid-operation.
   task automatic run_op(input logic clr, input logic drw, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] ia, input int inj_k,
                         output int lat, output logic col);
      @(negedge clock);
      bus.clear_start = clr;
      bus.draw_start  = drw;
      bus.sprite_x    = x;
      bus.sprite_y    = y;
      bus.sprite_n    = n;
      bus.sprite_addr = ia;
      t0     = cyc;
      wr_cnt = 0;
      rd_cnt = 0;
      lat    = -1;
      col    = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clock);
         bus.clear_start = 1'b0;
         bus.draw_start  = (k == inj_k);
         if (k == inj_k) begin
            bus.sprite_y = 8'd10;
            bus.sprite_n = 4'd1;
         end
         if (bus.done) begin
            lat = cyc - t0;
            col = bus.collision;
            break;
         end
      end
      bus.draw_start = 1'b0;
   endtask

   task automatic do_clear();
      int   lat;
      logic col;
      logic ok;
      run_op(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000, 0, lat, col);
      chk("clr_latency", lat, 33);
      chk("clr_collision", col, 1'b0);
      chk("clr_writes", wr_cnt, 32);
      ok = 1'b1;
      for (int k = 0; k < 32; k++)
         if (wr_row[k] != 5'(k) || wr_off[k] != k + 1) ok = 1'b0;
      chk("clr_row_order", ok, 1'b1);
   endtask

   typedef struct {
      logic        clr;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [3:0]  n;
      logic [11:0] ia;
      int          lat;
      logic        col;
      logic [4:0]  row;
      logic [63:0] rowv;
      int          wrs;
      logic [11:0] rd1;
   } vec_t;

   vec_t vt [10];

   initial begin
      int   lat;
      logic col;

      vt[0] = '{1'b1, 8'd0,  8'd0,  4'd5, 12'h050, 11, 1'b0, 5'd0,  64'hF000000000000000, 5, 12'h051};
      vt[1] = '{1'b0, 8'd0,  8'd0,  4'd5, 12'h050, 11, 1'b1, 5'd0,  64'h0000000000000000, 5, 12'h051};
      vt[2] = '{1'b1, 8'd60, 8'd3,  4'd1, 12'h100, 3,  1'b0, 5'd3,  64'h000000000000000F, 1, 12'h000};
      vt[3] = '{1'b1, 8'd70, 8'd3,  4'd1, 12'h100, 3,  1'b0, 5'd3,  64'h03FC000000000000, 1, 12'h000};
      vt[4] = '{1'b1, 8'd0,  8'd30, 4'd5, 12'h200, 5,  1'b0, 5'd31, 64'h5500000000000000, 2, 12'h201};
      vt[5] = '{1'b1, 8'd8,  8'd35, 4'd2, 12'hFFF, 5,  1'b0, 5'd4,  64'h003C000000000000, 2, 12'h000};
      vt[6] = '{1'b1, 8'd0,  8'd0,  4'd0, 12'h050, 1,  1'b0, 5'd0,  64'h0000000000000000, 0, 12'h000};
      vt[7] = '{1'b0, 8'd0,  8'd0,  4'd1, 12'h050, 3,  1'b0, 5'd0,  64'hF000000000000000, 1, 12'h000};
      vt[8] = '{1'b0, 8'd4,  8'd0,  4'd1, 12'h050, 3,  1'b0, 5'd0,  64'hFF00000000000000, 1, 12'h000};
      vt[9] = '{1'b0, 8'd2,  8'd0,  4'd1, 12'h051, 3,  1'b1, 5'd0,  64'hDB00000000000000, 1, 12'h000};

      for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
      ram[12'h050] = 8'hF0; ram[12'h051] = 8'h90; ram[12'h052] = 8'h90;
      ram[12'h053] = 8'h90; ram[12'h054] = 8'hF0;
      ram[12'h100] = 8'hFF;
      ram[12'h200] = 8'hAA; ram[12'h201] = 8'h55;
      ram[12'hFFF] = 8'h81; ram[12'h000] = 8'h3C;

      bus.draw_start  = 1'b0;
      bus.clear_start = 1'b0;
      bus.sprite_x    = '0;
      bus.sprite_y    = '0;
      bus.sprite_n    = '0;
      bus.sprite_addr = '0;
      resetN = 1'b0;
      #1;
      chk("rst_flags", {bus.busy, bus.done, bus.collision, bus.ram_rd_en, bus.fb_rd_en, bus.fb_we}, 6'b0);
      chk("rst_addrs", {bus.ram_rd_addr, bus.fb_addr}, 17'b0);
      chk("rst_wr_data", bus.fb_wr_data, 64'h0);
      @(negedge clock);
      resetN = 1'b1;

      for (int v = 0; v < 10; v++) begin
         if (vt[v].clr) do_clear();
         run_op(1'b0, 1'b1, vt[v].x, vt[v].y, vt[v].n, vt[v].ia, 0, lat, col);
         chk($sformatf("v%0d_latency", v), lat, vt[v].lat);
         chk($sformatf("v%0d_collision", v), col, vt[v].col);
         chk($sformatf("v%0d_writes", v), wr_cnt, vt[v].wrs);
         chk($sformatf("v%0d_reads", v), rd_cnt, vt[v].wrs);
         chk($sformatf("v%0d_row%0d", v, vt[v].row), fb[vt[v].row], vt[v].rowv);
         if (vt[v].wrs > 0) chk($sformatf("v%0d_rd_addr0", v), rd_log[0], vt[v].ia);
         if (vt[v].wrs > 1) chk($sformatf("v%0d_rd_addr1", v), rd_log[1], vt[v].rd1);
      end

      // Stray draw request while busy must be dropped.
      do_clear();
      run_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, 3, lat, col);
      chk("busy_ignore_latency", lat, 11);
      chk("busy_ignore_writes", wr_cnt, 5);
      chk("busy_ignore_row10", fb[10], 64'h0);
      chk("busy_ignore_row4", fb[4], 64'hF000000000000000);
      @(negedge clock);
      chk("after_done_busy_done", {bus.busy, bus.done}, 2'b00);

      // Simultaneous clear and draw: clear wins.
      run_op(1'b1, 1'b1, 8'd0, 8'd0, 4'd1, 12'h100, 0, lat, col);
      chk("both_latency", lat, 33);
      chk("both_writes", wr_cnt, 32);
      chk("both_row0", fb[0], 64'h0);

      // Reset in the middle of a five-row draw.
      @(negedge clock);
      bus.draw_start  = 1'b1;
      bus.sprite_x    = 8'd0;
      bus.sprite_y    = 8'd0;
      bus.sprite_n    = 4'd5;
      bus.sprite_addr = 12'h050;
      t0 = cyc;
      chk("accept_cycle_busy", bus.busy, 1'b0);
      @(negedge clock);
      bus.draw_start = 1'b0;
      chk("rd_cycle_busy", bus.busy, 1'b1);
      chk("rd_cycle_strobes", {bus.ram_rd_en, bus.fb_rd_en, bus.fb_we}, 3'b110);
      chk("rd_cycle_addr", bus.ram_rd_addr, 12'h050);
      @(negedge clock);
      chk("wr_cycle_strobes", {bus.ram_rd_en, bus.fb_rd_en, bus.fb_we}, 3'b001);
      @(negedge clock);
      @(negedge clock);
      resetN = 1'b0;
      #1;
      chk("midrst_flags", {bus.busy, bus.done, bus.collision, bus.ram_rd_en, bus.fb_rd_en, bus.fb_we}, 6'b0);
      chk("midrst_addrs", {bus.ram_rd_addr, bus.fb_addr}, 17'b0);
      chk("midrst_wr_data", bus.fb_wr_data, 64'h0);
      @(negedge clock);
      resetN = 1'b1;
      chk("midrst_row0_kept", fb[0], 64'hF000000000000000);
      chk("midrst_row1_unwritten", fb[1], 64'h0);
      run_op(1'b0, 1'b1, 8'd0, 8'd5, 4'd1, 12'h100, 0, lat, col);
      chk("post_rst_latency", lat, 3);
      chk("post_rst_row5", fb[5], 64'hFF00000000000000);
      chk("post_rst_collision", col, 1'b0);

      chk("strobe_rule_violations", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
Sequences the DRW (Dxyn) and CLS operations against the 64x32 monochrome framebuffer on behalf of the CPU. On a draw request it fetches n sprite bytes from program RAM starting at I, XORs each into the matching framebuffer row by read-modify-write, and reports collision. On a clear request it zeroes all rows. The CPU stalls on busy and samples collision into VF on done.

Parameters:
FB_ROWS, 32, framebuffer height in rows
FB_COLS, 64, framebuffer width in pixels (one row = one FB word)
ADDR_W, 12, program RAM address width

Ports:
clock  in  1  system clock
resetN  in  1  asynchronous active-low reset
draw_start  in  1  one-cycle draw request; sampled only in IDLE
clear_start  in  1  one-cycle clear request; sampled only in IDLE
sprite_x  in  8  Vx (column)
sprite_y  in  8  Vy (row)
sprite_n  in  4  sprite height in bytes
sprite_addr  in  ADDR_W  register I
busy  out  1  high from cycle after accept until done cycle inclusive
done  out  1  one-cycle completion pulse
collision  out  1  1 if any set pixel was cleared; valid with done, held until next accept
ram_rd_en  out  1  sprite byte read strobe
ram_rd_addr  out  ADDR_W  sprite byte address
ram_rd_data  in  8  sprite byte, valid 1 cycle after ram_rd_en
fb_addr  out  5  framebuffer row address
fb_rd_en  out  1  row read strobe
fb_rd_data  in  FB_COLS  row data, valid 1 cycle after fb_rd_en
fb_we  out  1  row write strobe
fb_wr_data  out  FB_COLS  row write data

Behaviour:
- One clock; reset asynchronous active-low. Reset: state IDLE, busy=0, done=0, collision=0, all strobes 0, all addresses/data 0. Reset mid-operation aborts; rows already written stay written.
- States: IDLE, CLR, RD, WR, DONE.
- IDLE: clear_start has priority over draw_start when both high. Accept at cycle T latches x0=sprite_x mod 64, y0=sprite_y mod 32, n, I, row index r=0, collision=0. Requests while not IDLE are ignored (not queued).
- Active rows m = min(n, 32-y0); rows past the bottom edge are clipped, no vertical wrap. m=0 (n=0) -> straight to DONE.
- RD: ram_rd_en=1, ram_rd_addr=(I+r) mod 4096; fb_rd_en=1, fb_addr=y0+r. Next state WR.
- WR: mask = {ram_rd_data, 56'b0} >> x0 (pixels past column 63 clipped, no horizontal wrap); fb_we=1, fb_addr=y0+r, fb_wr_data = fb_rd_data ^ mask; collision |= |(fb_rd_data & mask). r++; if r==m go DONE else RD.
- Bit mapping: FB bit 63 = column 0; sprite bit 7 = leftmost pixel.
- CLR: writes rows 0..31 with zeros on T+1..T+32 (fb_we=1, fb_addr=count), then DONE; collision=0.
- DONE: done=1 for one cycle, busy=1, then IDLE. Draw latency: done at T+2m+1. Clear: done at T+33.
- Strobes never asserted in IDLE or DONE; fb_we and fb_rd_en never high in the same cycle.

Decomposition:
- Shared package chip8_pkg: FB_ROWS, FB_COLS, FB_ROW_W=5, state enum type, font base address constant.
- One combinational sub-module sprite_row_xor: (old_row, sprite_byte, x0) -> (new_row, hit); holds the shift/clip/XOR/collision logic.

Test Plan:
- Clear at T -> 32 zero writes rows 0..31 on T+1..T+32, done at T+33, collision=0.
- After clear, draw x=0,y=0,n=5,I=0x050, RAM bytes F0 90 90 90 F0 -> rows 0..4 = {byte,56'h0}, done at T+11, collision=0; repeat same draw -> rows 0..4 = 0, collision=1.
- Draw x=60,y=3,n=1, byte FF on zero FB -> row 3 = 64'h000000000000000F (right clip), collision=0; x=70 -> treated as x=6, row = 64'h03FC000000000000.
- Draw y=30,n=5 -> exactly 2 writes (rows 30,31), RAM addresses I, I+1 only, done at T+5; I=0xFFF,n=2 -> second read at 0x000.
- n=0 -> no strobes, done at T+1, collision=0; draw_start during busy ignored; clear_start and draw_start together -> clear executes.
- Assert resetN low at T+4 of an n=5 draw -> all outputs 0 immediately, state IDLE; next draw_start accepted normally.
